// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-stage RISC-V ALU issue pipeline (decode/operands, then captured result)
// Optional branch support: define ALU_ISSUE_BRANCH_EN.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] imm_i,
  output logic [3:0]  ALU_OP_o,
  output logic [31:0] ALU_RS1_o,
  output logic [31:0] ALU_RS2_o,
  input  logic [31:0] ALU_RD_i,
  input  logic        ALU_ZR_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        branch_taken_o,
  output logic        illegal_o
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_SUM = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SRA = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000, OP_SUB = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1110, OP_SLTU = 4'b1111;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;

  logic        r_valid_a, r_illegal_a;
  logic [3:0]  r_op_a;
  logic [31:0] r_rs1_a, r_rs2_a;
  logic        r_valid_b, r_illegal_b, r_taken_b;
  logic [31:0] r_result_b;

  logic        w_adv_a, w_accept, w_alt;
  logic [3:0]  w_op;
  logic        w_use_imm, w_illegal;
  logic        w_taken_a;

  assign w_alt      = (funct7_i == 7'b0100000);
  assign w_adv_a    = r_valid_a && (!r_valid_b || out_ready_i);
  assign in_ready_o = !r_valid_a || w_adv_a;
  assign w_accept   = in_valid_i && in_ready_o;

`ifdef ALU_ISSUE_BRANCH_EN
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  logic w_is_branch, r_is_branch_a, r_br_inv_a;
  // BNE/BLT/BLTU are taken when the zero flag is clear; the others when it is set.
  assign w_taken_a = r_is_branch_a && !r_illegal_a && (ALU_ZR_i ^ r_br_inv_a);
`else
  logic w_unused_zr;
  assign w_unused_zr = ALU_ZR_i;
  assign w_taken_a   = 1'b0;
`endif

  always_comb begin
    w_op      = OP_AND;
    w_use_imm = 1'b0;
    w_illegal = 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
    w_is_branch = 1'b0;
`endif
    case (opcode_i)
      OPC_R, OPC_I: begin
        w_use_imm = (opcode_i == OPC_I);
        if (!w_use_imm)
          w_illegal = !((funct7_i == 7'd0) || w_alt) ||
                      (w_alt && (funct3_i != 3'b000) && (funct3_i != 3'b101));
        else if (funct3_i == 3'b001)
          w_illegal = (funct7_i != 7'd0);
        else if (funct3_i == 3'b101)
          w_illegal = !((funct7_i == 7'd0) || w_alt);
        case (funct3_i)
          3'b000:  w_op = (w_alt && !w_use_imm) ? OP_SUB : OP_SUM;
          3'b001:  w_op = OP_SLL;
          3'b010:  w_op = OP_SLT;
          3'b011:  w_op = OP_SLTU;
          3'b100:  w_op = OP_XOR;
          3'b101:  w_op = w_alt ? OP_SRA : OP_SRL;
          3'b110:  w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        w_op      = OP_SUM;
        w_use_imm = 1'b1;
      end
`ifdef ALU_ISSUE_BRANCH_EN
      OPC_BRANCH: begin
        w_is_branch = 1'b1;
        case (funct3_i)
          3'b000, 3'b001: w_op = OP_SUB;
          3'b100, 3'b101: w_op = OP_SLT;
          3'b110, 3'b111: w_op = OP_SLTU;
          default:        w_illegal = 1'b1;
        endcase
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_a   <= 1'b0;
      r_illegal_a <= 1'b0;
      r_op_a      <= 4'd0;
      r_rs1_a     <= 32'd0;
      r_rs2_a     <= 32'd0;
`ifdef ALU_ISSUE_BRANCH_EN
      r_is_branch_a <= 1'b0;
      r_br_inv_a    <= 1'b0;
`endif
    end else if (w_accept) begin
      // Illegal entries carry zeroed operands so the ALU sees an idle AND.
      r_valid_a   <= 1'b1;
      r_illegal_a <= w_illegal;
      r_op_a      <= w_illegal ? OP_AND : w_op;
      r_rs1_a     <= w_illegal ? 32'd0 : rs1_i;
      r_rs2_a     <= w_illegal ? 32'd0 : (w_use_imm ? imm_i : rs2_i);
`ifdef ALU_ISSUE_BRANCH_EN
      r_is_branch_a <= w_is_branch;
      r_br_inv_a    <= funct3_i[2] ^ funct3_i[0];
`endif
    end else if (w_adv_a) begin
      r_valid_a <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_b   <= 1'b0;
      r_illegal_b <= 1'b0;
      r_taken_b   <= 1'b0;
      r_result_b  <= 32'd0;
    end else if (w_adv_a) begin
      r_valid_b   <= 1'b1;
      r_illegal_b <= r_illegal_a;
      r_taken_b   <= w_taken_a;
`ifdef ALU_ISSUE_BRANCH_EN
      r_result_b  <= (r_illegal_a || r_is_branch_a) ? 32'd0 : ALU_RD_i;
`else
      r_result_b  <= r_illegal_a ? 32'd0 : ALU_RD_i;
`endif
    end else if (out_ready_i) begin
      r_valid_b <= 1'b0;
    end
  end

  assign ALU_OP_o       = r_valid_a ? r_op_a  : 4'd0;
  assign ALU_RS1_o      = r_valid_a ? r_rs1_a : 32'd0;
  assign ALU_RS2_o      = r_valid_a ? r_rs2_a : 32'd0;
  assign out_valid_o    = r_valid_b;
  assign result_o       = r_result_b;
  assign branch_taken_o = r_taken_b;
  assign illegal_o      = r_illegal_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with a behavioural ALU and reference model
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0, imm_i = '0;
  logic [3:0]  ALU_OP_o;
  logic [31:0] ALU_RS1_o, ALU_RS2_o;
  logic [31:0] ALU_RD_i;
  logic        ALU_ZR_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        branch_taken_o, illegal_o;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .ALU_OP_o(ALU_OP_o), .ALU_RS1_o(ALU_RS1_o), .ALU_RS2_o(ALU_RS2_o),
    .ALU_RD_i(ALU_RD_i), .ALU_ZR_i(ALU_ZR_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .branch_taken_o(branch_taken_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    ALU_RD_i = 32'd0;
    case (ALU_OP_o)
      4'b0000: ALU_RD_i = ALU_RS1_o & ALU_RS2_o;
      4'b0001: ALU_RD_i = ALU_RS1_o | ALU_RS2_o;
      4'b0010: ALU_RD_i = ALU_RS1_o + ALU_RS2_o;
      4'b0011: ALU_RD_i = {31'd0, ALU_RS1_o == ALU_RS2_o};
      4'b0100: ALU_RD_i = ALU_RS1_o << ALU_RS2_o[4:0];
      4'b0101: ALU_RD_i = ALU_RS1_o >> ALU_RS2_o[4:0];
      4'b0111: ALU_RD_i = $unsigned($signed(ALU_RS1_o) >>> ALU_RS2_o[4:0]);
      4'b1000: ALU_RD_i = ALU_RS1_o ^ ALU_RS2_o;
      4'b1001: ALU_RD_i = ~(ALU_RS1_o | ALU_RS2_o);
      4'b1010: ALU_RD_i = ALU_RS1_o - ALU_RS2_o;
      4'b1100: ALU_RD_i = {31'd0, $signed(ALU_RS1_o) >= $signed(ALU_RS2_o)};
      4'b1101: ALU_RD_i = {31'd0, ALU_RS1_o >= ALU_RS2_o};
      4'b1110: ALU_RD_i = {31'd0, $signed(ALU_RS1_o) < $signed(ALU_RS2_o)};
      4'b1111: ALU_RD_i = {31'd0, ALU_RS1_o < ALU_RS2_o};
      default: ALU_RD_i = 32'd0;
    endcase
  end
  assign ALU_ZR_i = (ALU_RD_i == 32'd0);

  // Architectural outcome {illegal, taken, result} of one instruction
  function automatic logic [33:0] ref_out(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b2, input logic [31:0] im);
    logic ill, tk, r_type, alt;
    logic [31:0] res, b;
    ill = 1'b0; tk = 1'b0; res = 32'd0;
    r_type = (op == 7'h33);
    alt = (f7 == 7'h20);
    b = r_type ? b2 : im;
    case (op)
      7'h33, 7'h13: begin
        if (r_type) begin
          if (f7 != 7'h00 && !alt) ill = 1'b1;
          if (alt && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
        end else begin
          if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
          if (f3 == 3'd5 && f7 != 7'h00 && !alt) ill = 1'b1;
        end
        case (f3)
          3'd0: res = (r_type && alt) ? a - b : a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
      7'h03, 7'h23: res = a + im;
`ifdef ALU_ISSUE_BRANCH_EN
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b2);
          3'd1: tk = (a != b2);
          3'd4: tk = ($signed(a) < $signed(b2));
          3'd5: tk = ($signed(a) >= $signed(b2));
          3'd6: tk = (a < b2);
          3'd7: tk = (a >= b2);
          default: ill = 1'b1;
        endcase
      end
`endif
      default: ill = 1'b1;
    endcase
    if (ill) begin res = 32'd0; tk = 1'b0; end
    return {ill, tk, res};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode_i = op; funct3_i = f3; funct7_i = f7; rs1_i = a; rs2_i = b; imm_i = im;
  endtask

  // Issues one instruction into an empty pipeline; reports what was seen in stages A and B
  task automatic issue_one(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
      output logic [3:0] aop, output logic va, output logic vb,
      output logic [31:0] res, output logic tk, output logic ill);
    set_instr(op, f3, f7, a, b, im);
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(negedge clk);
    aop = ALU_OP_o; va = out_valid_o;
    @(posedge clk); #1;
    @(negedge clk);
    vb = out_valid_o; res = result_o; tk = branch_taken_o; ill = illegal_o;
    @(posedge clk); #1;
  endtask

  task automatic gen_rand();
    logic [6:0] ops [6];
    logic [6:0] f7;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    ops[5] = 7'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h00;
      default: f7 = 7'($urandom);
    endcase
    set_instr(ops[$urandom_range(0, 5)], 3'($urandom), f7,
              ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
              ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom,
              $urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++; if (branch_taken_o !== 1'b0 || illegal_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", branch_taken_o, illegal_o); end
    checks++; if (ALU_OP_o !== 4'd0 || ALU_RS1_o !== 32'd0 || ALU_RS2_o !== 32'd0) begin failures++; $display("FAIL reset_alu_idle got=%h/%h/%h exp=0", ALU_OP_o, ALU_RS1_o, ALU_RS2_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    logic [3:0] aop; logic va, vb, tk, ill; logic [31:0] res;
    issue_one(7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd99, aop, va, vb, res, tk, ill);
    checks++; if (aop !== 4'b1010) begin failures++; $display("FAIL sub_alu_op got=%b exp=1010", aop); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL sub_early_valid got=%b exp=0", va); end
    checks++; if (vb !== 1'b1 || res !== 32'd7 || ill !== 1'b0) begin failures++; $display("FAIL sub_result got=v%b r=%h i=%b exp=v1 r=7 i=0", vb, res, ill); end
  endtask

  task automatic test_srai();
    logic [3:0] aop; logic va, vb, tk, ill; logic [31:0] res;
    issue_one(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'd4, aop, va, vb, res, tk, ill);
    checks++; if (aop !== 4'b0111) begin failures++; $display("FAIL srai_alu_op got=%b exp=0111", aop); end
    checks++; if (vb !== 1'b1 || res !== 32'hF800_0000) begin failures++; $display("FAIL srai_result got=v%b r=%h exp=v1 r=f8000000", vb, res); end
  endtask

  task automatic test_branch();
    logic [3:0] aop; logic va, vb, tk, ill; logic [31:0] res;
    logic e_tk1, e_ill;
`ifdef ALU_ISSUE_BRANCH_EN
    e_tk1 = 1'b1; e_ill = 1'b0;
`else
    e_tk1 = 1'b0; e_ill = 1'b1;
`endif
    issue_one(7'h63, 3'd0, 7'h00, 32'd5, 32'd5, 32'd0, aop, va, vb, res, tk, ill);
    checks++; if (vb !== 1'b1 || tk !== e_tk1 || res !== 32'd0 || ill !== e_ill) begin failures++; $display("FAIL beq got=v%b t=%b r=%h i=%b exp=v1 t=%b r=0 i=%b", vb, tk, res, ill, e_tk1, e_ill); end
    issue_one(7'h63, 3'd5, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, aop, va, vb, res, tk, ill);
    checks++; if (vb !== 1'b1 || tk !== 1'b0 || res !== 32'd0 || ill !== e_ill) begin failures++; $display("FAIL bge got=v%b t=%b r=%h i=%b exp=v1 t=0 r=0 i=%b", vb, tk, res, ill, e_ill); end
  endtask

  task automatic test_illegal();
    logic [3:0] aop; logic va, vb, tk, ill; logic [31:0] res;
    issue_one(7'h7F, 3'd0, 7'h00, 32'd123, 32'd456, 32'd7, aop, va, vb, res, tk, ill);
    checks++; if (vb !== 1'b1 || ill !== 1'b1 || res !== 32'd0 || tk !== 1'b0) begin failures++; $display("FAIL illegal_opcode got=v%b i=%b r=%h t=%b exp=v1 i=1 r=0 t=0", vb, ill, res, tk); end
    checks++; if (aop !== 4'd0) begin failures++; $display("FAIL illegal_alu_op got=%b exp=0000", aop); end
    issue_one(7'h33, 3'd4, 7'h20, 32'd1, 32'd2, 32'd0, aop, va, vb, res, tk, ill);
    checks++; if (ill !== 1'b1 || res !== 32'd0) begin failures++; $display("FAIL illegal_alt_xor got=i%b r=%h exp=i1 r=0", ill, res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [4];
    int sent, recv, stall_at;
    sent = 0; recv = 0; stall_at = -1;
    for (int k = 0; k < 4; k++) exp_r[k] = 32'd100 * 32'(k + 1) + 32'd7;
    for (int c = 0; c < 40 && recv < 4; c++) begin
      in_valid_i = (sent < 4);
      if (sent < 4) set_instr(7'h33, 3'd0, 7'h00, 32'd100 * 32'(sent + 1), 32'd7, 32'd0);
      out_ready_i = (c >= 3);
      @(negedge clk);
      if (in_valid_i && !in_ready_o && stall_at < 0) stall_at = sent;
      if (out_valid_o) begin
        checks++;
        if (recv >= 4 || result_o !== exp_r[recv]) begin failures++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", recv, result_o, exp_r[recv % 4]); end
        if (out_ready_i) recv++;
      end
      if (in_valid_i && in_ready_o) sent++;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    checks++; if (stall_at !== 2) begin failures++; $display("FAIL b2b_stall_point got=%0d exp=2", stall_at); end
    checks++; if (recv !== 4 || sent !== 4) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=4/4", sent, recv); end
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [33:0] e;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 7);
      gen_rand();
      @(negedge clk);
      if (out_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_unexpected_output r=%h", result_o); end
        else begin
          e = exp_q[0];
          if ({illegal_o, branch_taken_o, result_o} !== e) begin failures++; $display("FAIL rand_out cyc=%0d got=%b/%b/%h exp=%b/%b/%h", c, illegal_o, branch_taken_o, result_o, e[33], e[32], e[31:0]); end
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(ref_out(opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, imm_i));
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid_o) begin
        e = exp_q.pop_front();
        checks++;
        if ({illegal_o, branch_taken_o, result_o} !== e) begin failures++; $display("FAIL rand_drain got=%b/%b/%h exp=%b/%b/%h", illegal_o, branch_taken_o, result_o, e[33], e[32], e[31:0]); end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    set_instr(7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0);
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk); #1;
    in_valid_i = 1'b0; rst = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL midreset_state got=v%b r%b exp=v0 r1", out_valid_o, in_ready_o); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid_o) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_ghost got=%0d exp=0", seen); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sub();
    test_srai();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have in_valid_i/in_ready_o, in/out, 1 each, upstream valid/ready handshake; transfer when both high at a clock edge.
REQ-004 SHALL have opcode_i[6:0], funct3_i[2:0], funct7_i[6:0], inputs, RISC-V instruction fields.
REQ-005 SHALL have rs1_i, rs2_i, imm_i, inputs, 32 each, register operands and sign-extended immediate.
REQ-006 SHALL have ALU_OP_o[3:0], ALU_RS1_o[31:0], ALU_RS2_o[31:0], outputs, drive the combinational ALU.
REQ-007 SHALL have ALU_RD_i[31:0], ALU_ZR_i, inputs, ALU result and zero flag, same cycle.
REQ-008 SHALL have out_valid_o/out_ready_i, out/in, 1 each, downstream handshake.
REQ-009 SHALL have result_o[31:0], branch_taken_o, illegal_o, outputs, qualified by out_valid_o.

Function
REQ-010 SHALL be two registered stages: A (decoded op + operands, drives ALU) and B (captured result).
REQ-011 SHALL assert in_ready_o = !valid_A || adv_A, where adv_A = valid_A && (!valid_B || out_ready_i).
REQ-012 SHALL present a result on out_valid_o exactly 2 cycles after acceptance when downstream never stalls; throughput 1/cycle.
REQ-013 SHALL hold stage B contents stable while out_valid_o=1 and out_ready_i=0; stage A holds if B is full and not draining.
REQ-014 SHALL encode ALU ops: AND 0000, OR 0001, SUM 0010, EQUAL 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1000, NOR 1001, SUB 1010, GE 1100, GEU 1101, SLT 1110, SLTU 1111.
REQ-015 SHALL decode opcode 0110011 (R-type) by funct3: 000 SUM (SUB if funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7=0100000), 110 OR, 111 AND; operand2 = rs2_i.
REQ-016 SHALL decode opcode 0010011 (I-type) identically with operand2 = imm_i, except funct3=000 always SUM; funct7 checked only for shifts.
REQ-017 SHALL decode 0000011 and 0100011 (load/store address) as SUM with operand2 = imm_i.
REQ-018 SHALL decode 1100011 (branch) with operand2 = rs2_i: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU; funct3 010/011 illegal.
REQ-019 SHALL compute branch_taken in stage A from ALU_ZR_i: BEQ ZR=1, BNE ZR=0, BLT/BLTU ZR=0, BGE/BGEU ZR=1; register into B.
REQ-020 SHALL flag illegal for any other opcode, R-type funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not 000/101; illegal entries flow through with result_o=0, branch_taken_o=0, illegal_o=1.
REQ-021 SHALL drive ALU_OP_o=0000 and ALU operands 0 when valid_A=0.
REQ-022 SHALL capture ALU_RD_i into result_o for non-branch legal ops; branches SHALL produce result_o=0.

Reset
REQ-023 SHALL clear valid_A, valid_B, and all stage registers to 0 on rst, regardless of handshake state.
REQ-024 SHALL hold in_ready_o=1, out_valid_o=0, result_o=0, branch_taken_o=0, illegal_o=0 in the cycle after reset.
REQ-025 SHALL discard any in-flight instruction when rst asserts mid-operation; no output handshake occurs for it.

Configuration
REQ-026 SHALL use macro ALU_ISSUE_BRANCH_EN: defined -> REQ-018/019 active; undefined -> opcode 1100011 illegal, branch_taken_o tied 0, no branch logic synthesized.

Verification
REQ-027 SHALL check R-type SUB (funct7=0100000,funct3=000) rs1=10, rs2=3 -> ALU_OP_o=1010, result_o=7 two cycles later.
REQ-028 SHALL check I-type SRAI imm=4, rs1=0x80000000 -> ALU_OP_o=0111, result_o=0xF8000000.
REQ-029 SHALL check BEQ rs1=rs2=5 -> branch_taken_o=1, result_o=0; BGE rs1=-1, rs2=1 -> branch_taken_o=0 (without macro: illegal_o=1).
REQ-030 SHALL check back-to-back 4 ADDs with out_ready_i low for 3 cycles -> in_ready_o drops after 2 accepts, all 4 results delivered in order, none lost or duplicated.
REQ-031 SHALL check opcode 1111111 -> illegal_o=1, result_o=0; rst asserted while valid_A=1 -> out_valid_o=0 next cycle.
